imem_arbiter: RTL
=================

# imem_arbiter

Shares the single-ported, synchronous-read instruction memory between the pipeline fetch stage (IF) and the UART program loader/debug port (LD). It issues at most one memory access per cycle and routes read data back to the owner. It also sequences a program-download session: it holds IF off while code is rewritten, then pulses a pipeline flush so execution restarts on the new image. The block sits between the IF stage and the instruction RAM, which replaces the fixed 256-word program store.

## Interface
Parameters:
- ADDR_W, 8, memory word-index width (256 words, byte address bits [ADDR_W+1:2])
- STARVE_MAX, 4, consecutive denied LD cycles after which LD wins over IF

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request
- if_addr  in  32  fetch byte address (PC)
- if_stall  out  1  combinational; fetch not accepted this cycle
- if_valid  out  1  registered; if_data valid
- if_data  out  32  registered fetch data
- if_flush  out  1  registered one-cycle pulse at end of download session
- ld_req  in  1  loader access request
- ld_we  in  1  1 = write, 0 = read
- ld_lock  in  1  download session active
- ld_addr  in  32  loader byte address
- ld_wdata  in  32  loader write data
- ld_gnt  out  1  combinational; loader access issued this cycle
- ld_rvalid  out  1  registered; ld_rdata valid
- ld_rdata  out  32  registered read data
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  word index
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data, valid one cycle after mem_en && !mem_we

## Operation
- FSM states: RUN, LOCK, FLUSH. Reset state is RUN.
- RUN -> LOCK when ld_lock=1. LOCK -> FLUSH when ld_lock=0. FLUSH -> RUN unconditionally after 1 cycle.
- RUN arbitration:
  - IF wins by default.
  - LD wins when ld_req=1 and starve_cnt==STARVE_MAX, or when if_req=0.
  - Loser is stalled: if_stall=1, or ld_gnt=0.
- starve_cnt: increments, saturating at STARVE_MAX, on each cycle with ld_req && !ld_gnt. Clears on any ld_gnt and whenever ld_req=0.
- LOCK: if_stall=if_req every cycle. ld_gnt=ld_req every cycle.
- FLUSH: if_stall=if_req, ld_gnt=0, if_flush=1 (registered, so high exactly for the FLUSH cycle).
- Range check: an address is in range when bits [31:ADDR_W+2] are zero. Bits [1:0] are ignored.
  - Out-of-range access is still accepted or granted, but mem_en=0.
  - An out-of-range read returns 0x00000000 with the normal valid timing.
  - An out-of-range write is dropped.
- Owner register records the granted reader and the range flag so mem_rdata is steered to exactly one of if_data or ld_rdata the next cycle. The data output that is not steered holds its previous value.
- Only the winner drives mem_addr and mem_wdata. When idle, mem_en=0 and mem_we=0.

## Timing
- Reset values: if_valid=0, if_data=0, if_flush=0, ld_rvalid=0, ld_rdata=0, starve_cnt=0, state=RUN.
- While reset=1: mem_en=0, ld_gnt=0, if_stall=0.
- Fetch latency: accepted in cycle N (if_req && !if_stall) gives if_valid=1 and if_data in cycle N+1. Back-to-back fetches sustain 1 word/cycle.
- LD read: ld_gnt in cycle N gives ld_rvalid=1 and ld_rdata in cycle N+1.
- LD write: memory updated at the edge ending cycle N. No response.
- Read-after-write to the same address from either port in consecutive cycles returns the new data; the memory is write-first, and this block adds no bypass.
- Maximum IF stall in RUN under continuous ld_req is 1 cycle per STARVE_MAX+1 cycles.
- ld_lock deasserted in the same cycle it is asserted: one LOCK cycle, then FLUSH.
- Reset mid-session: state returns to RUN and no flush pulse is generated. Pending rvalids are killed.

## Test plan
- Preload word 3 = 0x200D0008. IF reads 0x0000000C in cycle N -> if_valid=1 and if_data=0x200D0008 in N+1; if_stall=0 throughout.
- if_req held 1 and ld_req held 1 (read 0x10) with STARVE_MAX=4 -> ld_gnt on every 5th cycle; IF stalled only in those cycles; ld_rdata = word 4.
- ld_lock=1, then write 0x08000003 to 0x00000000, then ld_lock=0 -> if_stall=1 during LOCK; if_flush=1 for exactly one cycle; next IF fetch of 0x0 returns 0x08000003.
- IF fetch of 0x00000400 (out of range for ADDR_W=8) -> mem_en=0; if_valid=1 with if_data=0 next cycle. LD write to 0x00000400 -> no memory write.
- Assert reset during LOCK with a read granted -> next cycle: state RUN, ld_rvalid=0, if_flush=0, and all registered outputs 0.
- if_req=0 with ld_req=1 continuously -> ld_gnt=1 every cycle and starve_cnt stays 0.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the fetch stage, the program loader and the instruction RAM.
// The arbiter connects through the slave modport; the surrounding logic uses the master modport.
interface imem_arbiter_if #(
    parameter int unsigned ADDR_W = 8
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_stall;
    logic              if_valid;
    logic [31:0]       if_data;
    logic              if_flush;

    logic              ld_req;
    logic              ld_we;
    logic              ld_lock;
    logic [31:0]       ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [31:0]       ld_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_stall, if_valid, if_data, if_flush,
        input  ld_req, ld_we, ld_lock, ld_addr, ld_wdata,
        output ld_gnt, ld_rvalid, ld_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_stall, if_valid, if_data, if_flush,
        output ld_req, ld_we, ld_lock, ld_addr, ld_wdata,
        input  ld_gnt, ld_rvalid, ld_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/imem_arbiter.sv
// Single-port instruction RAM arbiter between fetch (IF) and program loader (LD),
// with a download-session sequencer that holds IF off and pulses a flush afterwards.
module imem_arbiter #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    imem_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {RUN, LOCK, FLUSH} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic             if_own_q, if_rng_q;
    logic             ld_own_q, ld_rng_q;
    logic [31:0]      if_hold_q, ld_hold_q;
    logic             if_flush_q;

    logic             if_acc, ld_win;
    logic             if_in_rng, ld_in_rng;
    logic [31:0]      if_rd, ld_rd;
    logic             unused_addr_bits;

    assign if_in_rng        = (bus.if_addr[31:ADDR_W+2] == '0);
    assign ld_in_rng        = (bus.ld_addr[31:ADDR_W+2] == '0);
    assign unused_addr_bits = ^{bus.if_addr[1:0], bus.ld_addr[1:0]};

    always_comb begin
        if_acc       = 1'b0;
        ld_win       = 1'b0;
        bus.ld_gnt   = 1'b0;
        bus.if_stall = 1'b0;
        if (!reset) begin
            case (state_q)
                RUN: begin
                    ld_win = bus.ld_req &&
                             ((starve_q == CNT_W'(STARVE_MAX)) || !bus.if_req);
                    bus.ld_gnt   = ld_win;
                    bus.if_stall = bus.if_req && ld_win;
                    if_acc       = bus.if_req && !ld_win;
                end
                LOCK: begin
                    bus.if_stall = bus.if_req;
                    bus.ld_gnt   = bus.ld_req;
                end
                FLUSH: begin
                    bus.if_stall = bus.if_req;
                end
                default: ;
            endcase
        end
    end

    // Out-of-range accesses are still granted but never reach the RAM.
    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (bus.ld_gnt) begin
            bus.mem_en    = ld_in_rng;
            bus.mem_we    = bus.ld_we && ld_in_rng;
            bus.mem_addr  = bus.ld_addr[ADDR_W+1:2];
            bus.mem_wdata = bus.ld_wdata;
        end else if (if_acc) begin
            bus.mem_en    = if_in_rng;
            bus.mem_addr  = bus.if_addr[ADDR_W+1:2];
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!bus.ld_req || bus.ld_gnt)
            starve_d = '0;
        else if (starve_q != CNT_W'(STARVE_MAX))
            starve_d = starve_q + 1'b1;
    end

    // The RAM output register supplies the data; the hold registers keep the
    // last value on whichever side was not the reader.
    assign if_rd         = if_rng_q ? bus.mem_rdata : '0;
    assign ld_rd         = ld_rng_q ? bus.mem_rdata : '0;
    assign bus.if_data   = if_own_q ? if_rd : if_hold_q;
    assign bus.ld_rdata  = ld_own_q ? ld_rd : ld_hold_q;
    assign bus.if_valid  = if_own_q;
    assign bus.ld_rvalid = ld_own_q;
    assign bus.if_flush  = if_flush_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            starve_q   <= '0;
            if_own_q   <= 1'b0;
            if_rng_q   <= 1'b0;
            ld_own_q   <= 1'b0;
            ld_rng_q   <= 1'b0;
            if_hold_q  <= '0;
            ld_hold_q  <= '0;
            if_flush_q <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            if_own_q   <= if_acc;
            if_rng_q   <= if_in_rng;
            ld_own_q   <= bus.ld_gnt && !bus.ld_we;
            ld_rng_q   <= ld_in_rng;
            if (if_own_q) if_hold_q <= if_rd;
            if (ld_own_q) ld_hold_q <= ld_rd;
            if_flush_q <= 1'b0;
            case (state_q)
                RUN:     if (bus.ld_lock) state_q <= LOCK;
                LOCK: begin
                    if (!bus.ld_lock) begin
                        state_q    <= FLUSH;
                        if_flush_q <= 1'b1;
                    end
                end
                FLUSH:   state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end
endmodule
